vend_txn_ctrl: RTL and testbench
================================

// Module: vend_txn_ctrl
// PURPOSE
//  Transaction sequencer for the vending machine. Arbitrates the three product buttons and accumulates coin credit.
//  Hands the vend to the dispenser mechanism through a req/ack handshake, then pays change coin-by-coin through the coin ejector.
//  Sits between the front panel (BTN1..3, Money_in) and the dispenser/ejector actuators; drives the credit display value.
// PARAMETERS
//  CW      5  credit register width (zl)
//  PRICE1  2  product1 (tea) price, zl
//  PRICE2  3  product2 (coffee) price, zl
//  PRICE3  4  product3 (hot chocolate) price, zl
//  TMO     64 idle-coin timeout, cycles (only with VEND_TIMEOUT_EN)
// PORTS
//  clk        in  1   system clock, rising edge
//  reset      in  1   synchronous, active-high
//  BTN1..BTN3 in  1   product select buttons, level
//  cancel     in  1   abort request, level
//  Money_in   in  3   coin code, level: 001=1zl 010=2zl 100=5zl, 000=none
//  disp_ack   in  1   dispenser done
//  coin_ack   in  1   ejector released coin
//  product    out 3   one-hot latched selection (LED drive)
//  credit     out CW  current credit, zl
//  disp_req   out 1   dispense request
//  coin_req   out 1   eject request
//  coin_type  out 3   coin to eject, Money_in encoding
//  delivered  out 1   1-cycle pulse, vend complete
//  bad_coin   out 1   1-cycle pulse, reserved code accepted
//  busy       out 1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; coin-edge history 000.
//  Coin event = Money_in!=000 and previous-cycle Money_in==000 (rising edge); held level counts once.
//  Codes 011/101/110/111 on an event: no credit, bad_coin pulse.
//  IDLE: any BTNx -> latch lowest index (BTN1>BTN2>BTN3), product one-hot, -> COLLECT next cycle. Coins ignored.
//  COLLECT: valid coin event -> credit+=value next cycle, saturating at 2^CW-1.
//   credit>=price (registered compare, cycle after update) -> VEND.
//   cancel (priority over compare) -> CHANGE with product cleared, no delivery.
//  VEND: disp_req=1 held until disp_ack sampled high; credit-=price on the ack cycle -> CHANGE.
//  CHANGE: credit==0 -> DONE. Else coin_type = greedy largest coin <= credit (5,2,1); coin_req=1 until coin_ack.
//   On ack: credit-=value, drop coin_req one cycle, re-evaluate.
//  DONE: delivered=1 for one cycle if a vend occurred; product cleared; -> IDLE.
//  Buttons, cancel, coins ignored outside their states; acks outside their handshake ignored.
//  coin_type is stable while coin_req is high.
//  reset mid-transaction: immediate IDLE, credit lost (operator recovery), no pulses.
// CONFIGURATION
//  VEND_TIMEOUT_EN defined: counter resets on each coin event; in COLLECT, TMO cycles without a coin -> CHANGE (refund), same as cancel.
//  Undefined: COLLECT waits indefinitely; counter logic absent.
// STRUCTURE
//  vend_pkg: state encoding (IDLE,COLLECT,VEND,CHANGE,DONE), coin codes, coin value function, default prices.
//  Sub-module vend_change_sel: combinational greedy coin chooser (credit -> coin_type, value); instanced once.
// TESTING
//  BTN1, then Money_in=010 -> disp_req; ack -> credit 0, no coin_req, delivered pulse.
//  BTN1, 5zl -> vend, then coin_type 010 then 001 (change 3), credit 0, delivered.
//  BTN1+BTN3 together, 1zl+1zl -> product=001, vends at credit 2, not 4.
//  BTN3, 2zl, cancel -> refund one 2zl, no disp_req, no delivered.
//  Money_in held 010 for 20 cycles -> credit +2 once; 011 -> bad_coin, credit unchanged.
//  reset asserted during CHANGE with coin_req high -> next cycle all outputs 0, busy 0.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types for the vending transaction sequencer: state encoding, coin codes,
// coin value decode and default product prices.
package vend_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StVend,
      StChange,
      StDone
   } state_e;

   localparam logic [2:0] CoinNone = 3'b000;
   localparam logic [2:0] Coin1    = 3'b001;
   localparam logic [2:0] Coin2    = 3'b010;
   localparam logic [2:0] Coin5    = 3'b100;

   localparam int unsigned DefPrice1 = 2;
   localparam int unsigned DefPrice2 = 3;
   localparam int unsigned DefPrice3 = 4;

   function automatic logic coin_valid(input logic [2:0] code);
      return (code == Coin1) || (code == Coin2) || (code == Coin5);
   endfunction

   function automatic logic [2:0] coin_value(input logic [2:0] code);
      case (code)
         Coin1:   return 3'd1;
         Coin2:   return 3'd2;
         Coin5:   return 3'd5;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Front panel / actuator bundle of the vending sequencer.
// master = sequencer side, slave = panel, dispenser and ejector side.
interface vend_txn_ctrl_if #(
   parameter int unsigned CW = 5
);
   logic          BTN1;
   logic          BTN2;
   logic          BTN3;
   logic          cancel;
   logic [2:0]    Money_in;
   logic          disp_ack;
   logic          coin_ack;
   logic [2:0]    product;
   logic [CW-1:0] credit;
   logic          disp_req;
   logic          coin_req;
   logic [2:0]    coin_type;
   logic          delivered;
   logic          bad_coin;
   logic          busy;

   modport master (
      input  BTN1, BTN2, BTN3, cancel, Money_in, disp_ack, coin_ack,
      output product, credit, disp_req, coin_req, coin_type, delivered, bad_coin, busy
   );

   modport slave (
      output BTN1, BTN2, BTN3, cancel, Money_in, disp_ack, coin_ack,
      input  product, credit, disp_req, coin_req, coin_type, delivered, bad_coin, busy
   );

endinterface

// File: rtl/vend_change_sel.sv
// Greedy change chooser: largest coin (5, 2, 1) not exceeding the remaining credit.
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int unsigned CW = 5
) (
   input  logic [CW-1:0] credit_i,
   output logic [2:0]    coin_type_o,
   output logic [2:0]    value_o
);

   always_comb begin
      coin_type_o = CoinNone;
      value_o     = 3'd0;
      if (credit_i >= CW'(5)) begin
         coin_type_o = Coin5;
         value_o     = 3'd5;
      end else if (credit_i >= CW'(2)) begin
         coin_type_o = Coin2;
         value_o     = 3'd2;
      end else if (credit_i != '0) begin
         coin_type_o = Coin1;
         value_o     = 3'd1;
      end
   end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: button arbitration, coin credit, dispense handshake, change payout.
// Optional idle-coin refund timeout enabled by defining VEND_TIMEOUT_EN.
module vend_txn_ctrl
   import vend_pkg::*;
#(
   parameter int unsigned CW     = 5,
   parameter int unsigned PRICE1 = DefPrice1,
   parameter int unsigned PRICE2 = DefPrice2,
`ifdef VEND_TIMEOUT_EN
   parameter int unsigned PRICE3 = DefPrice3,
   parameter int unsigned TMO    = 64
`else
   parameter int unsigned PRICE3 = DefPrice3
`endif
) (
   input logic              clk,
   input logic              reset,
   vend_txn_ctrl_if.master  bus
);

   state_e        state_q, state_d;
   logic [2:0]    product_q, product_d;
   logic [CW-1:0] credit_q, credit_d;
   logic [2:0]    money_prev_q;
   logic          ge_q, ge_d;
   logic          vended_q, vended_d;
   logic          coin_req_q, coin_req_d;
   logic [2:0]    coin_type_q, coin_type_d;
   logic          delivered_q, delivered_d;
   logic          bad_coin_q, bad_coin_d;

   logic [CW-1:0] price;
   logic          coin_evt;
   logic [CW:0]   credit_sum;
   logic [CW-1:0] credit_sat;
   logic [2:0]    sel_type;
   logic [2:0]    sel_value;
   logic          tmo_hit;

   vend_change_sel #(
      .CW (CW)
   ) u_change_sel (
      .credit_i    (credit_q),
      .coin_type_o (sel_type),
      .value_o     (sel_value)
   );

   always_comb begin
      if (product_q[0])      price = CW'(PRICE1);
      else if (product_q[1]) price = CW'(PRICE2);
      else                   price = CW'(PRICE3);
   end

   // A coin counts once, on the transition away from the idle code.
   assign coin_evt   = (bus.Money_in != CoinNone) && (money_prev_q == CoinNone);
   assign credit_sum = {1'b0, credit_q} + (CW+1)'(coin_value(bus.Money_in));
   assign credit_sat = credit_sum[CW] ? '1 : credit_sum[CW-1:0];

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_q;

   always_ff @(posedge clk) begin
      if (reset || (state_q != StCollect) || coin_evt) tmo_q <= '0;
      else                                            tmo_q <= tmo_q + 1'b1;
   end

   assign tmo_hit = (state_q == StCollect) && !coin_evt && (tmo_q == TW'(TMO - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      product_d   = product_q;
      credit_d    = credit_q;
      ge_d        = 1'b0;
      vended_d    = vended_q;
      coin_req_d  = coin_req_q;
      coin_type_d = coin_type_q;
      delivered_d = 1'b0;
      bad_coin_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.BTN1 || bus.BTN2 || bus.BTN3) begin
               if (bus.BTN1)      product_d = 3'b001;
               else if (bus.BTN2) product_d = 3'b010;
               else               product_d = 3'b100;
               state_d = StCollect;
            end
         end
         StCollect: begin
            ge_d = (credit_q >= price);
            if (coin_evt) begin
               if (coin_valid(bus.Money_in)) credit_d   = credit_sat;
               else                          bad_coin_d = 1'b1;
            end
            if (bus.cancel || tmo_hit) begin
               product_d = '0;
               state_d   = StChange;
            end else if (ge_q) begin
               state_d = StVend;
            end
         end
         StVend: begin
            if (bus.disp_ack) begin
               credit_d = credit_q - price;
               vended_d = 1'b1;
               state_d  = StChange;
            end
         end
         StChange: begin
            // coin_req drops for one cycle after each ack so the next coin is re-chosen.
            if (coin_req_q) begin
               if (bus.coin_ack) begin
                  credit_d    = credit_q - CW'(sel_value);
                  coin_req_d  = 1'b0;
                  coin_type_d = CoinNone;
               end
            end else if (credit_q == '0) begin
               state_d = StDone;
            end else begin
               coin_req_d  = 1'b1;
               coin_type_d = sel_type;
            end
         end
         StDone: begin
            delivered_d = vended_q;
            vended_d    = 1'b0;
            product_d   = '0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         product_q    <= '0;
         credit_q     <= '0;
         money_prev_q <= CoinNone;
         ge_q         <= 1'b0;
         vended_q     <= 1'b0;
         coin_req_q   <= 1'b0;
         coin_type_q  <= CoinNone;
         delivered_q  <= 1'b0;
         bad_coin_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         product_q    <= product_d;
         credit_q     <= credit_d;
         money_prev_q <= bus.Money_in;
         ge_q         <= ge_d;
         vended_q     <= vended_d;
         coin_req_q   <= coin_req_d;
         coin_type_q  <= coin_type_d;
         delivered_q  <= delivered_d;
         bad_coin_q   <= bad_coin_d;
      end
   end

   assign bus.product   = product_q;
   assign bus.credit    = credit_q;
   assign bus.disp_req  = (state_q == StVend);
   assign bus.coin_req  = coin_req_q;
   assign bus.coin_type = coin_type_q;
   assign bus.delivered = delivered_q;
   assign bus.bad_coin  = bad_coin_q;
   assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Scoreboard bench for vend_txn_ctrl: directed scenarios then randomized transactions,
// with expected events queued by a transaction-level model and checked by a monitor.
module tb_vend_txn_ctrl;

   localparam int unsigned CW = 5;
   localparam int EvDisp  = 0;
   localparam int EvCoin  = 1;
   localparam int EvDeliv = 2;
   localparam int EvBad   = 3;

   typedef struct {
      int kind;
      int val;
      int prod;
   } exp_t;

   logic       clk;
   logic       reset;
   exp_t       expq[$];
   logic [2:0] plan[$];
   int         total;
   int         bad;
   int         m_credit;
   int         m_price;
   int         m_prod;
   bit         m_done;

   vend_txn_ctrl_if #(.CW(CW)) bus ();

   vend_txn_ctrl #(.CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push(input int kind, input int val, input int prod);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.prod = prod;
      expq.push_back(e);
   endtask

   task automatic take(input int want, input string name, output exp_t e, output bit ok);
      e  = '{kind: -1, val: -1, prod: -1};
      ok = 1'b0;
      if (expq.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: actual=event seen required=no event", name);
      end else begin
         e = expq.pop_front();
         check(name, want, e.kind);
         ok = (e.kind == want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int code_val(input logic [2:0] code);
      case (code)
         3'b001:  return 1;
         3'b010:  return 2;
         3'b100:  return 5;
         default: return -1;
      endcase
   endfunction

   // Refund or change is paid largest coin first; values are coin codes.
   task automatic push_change(input int amount);
      int c = amount;
      while (c > 0) begin
         if (c >= 5) begin
            push(EvCoin, 4, 0);
            c -= 5;
         end else if (c >= 2) begin
            push(EvCoin, 2, 0);
            c -= 2;
         end else begin
            push(EvCoin, 1, 0);
            c -= 1;
         end
      end
   endtask

   task automatic start_txn(input logic [2:0] btns);
      if (btns[0]) begin
         m_prod  = 1;
         m_price = 2;
      end else if (btns[1]) begin
         m_prod  = 2;
         m_price = 3;
      end else begin
         m_prod  = 4;
         m_price = 4;
      end
      m_credit = 0;
      m_done   = 1'b0;
      bus.BTN1 = btns[0];
      bus.BTN2 = btns[1];
      bus.BTN3 = btns[2];
      tick();
      bus.BTN1 = 1'b0;
      bus.BTN2 = 1'b0;
      bus.BTN3 = 1'b0;
      check("latched_product", int'(bus.product), m_prod);
   endtask

   task automatic coin_step(input logic [2:0] code, input int hold);
      int v = code_val(code);
      if (v < 0) begin
         push(EvBad, 0, 0);
      end else begin
         m_credit = (m_credit + v > 31) ? 31 : m_credit + v;
         if (m_credit >= m_price) begin
            push(EvDisp, m_credit, m_prod);
            push_change(m_credit - m_price);
            push(EvDeliv, 0, 0);
            m_done = 1'b1;
         end
      end
      bus.Money_in = code;
      repeat (hold) tick();
      bus.Money_in = 3'b000;
      repeat (4) tick();
   endtask

   task automatic do_cancel();
      push_change(m_credit);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
   endtask

   task automatic finish_txn();
      int n = 0;
      while (bus.busy && n < 300) begin
         tick();
         n++;
      end
      check("txn_idle", int'(bus.busy), 0);
      repeat (3) tick();
      check("queue_drained", expq.size(), 0);
      check("end_credit", int'(bus.credit), 0);
      check("end_product", int'(bus.product), 0);
      expq.delete();
   endtask

   task automatic run_txn(input logic [2:0] btns, input int cancel_after);
      bit cancelled = 1'b0;
      start_txn(btns);
      if (cancel_after == 0) begin
         do_cancel();
         cancelled = 1'b1;
      end else begin
         for (int i = 0; i < plan.size() && !m_done && !cancelled; i++) begin
            coin_step(plan[i], int'($urandom_range(1, 3)));
            if (!m_done && cancel_after == i + 1) begin
               do_cancel();
               cancelled = 1'b1;
            end
         end
      end
      while (!m_done && !cancelled) coin_step(3'b100, 1);
      finish_txn();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_product"},   int'(bus.product), 0);
      check({tag, "_credit"},    int'(bus.credit), 0);
      check({tag, "_disp_req"},  int'(bus.disp_req), 0);
      check({tag, "_coin_req"},  int'(bus.coin_req), 0);
      check({tag, "_coin_type"}, int'(bus.coin_type), 0);
      check({tag, "_delivered"}, int'(bus.delivered), 0);
      check({tag, "_bad_coin"},  int'(bus.bad_coin), 0);
      check({tag, "_busy"},      int'(bus.busy), 0);
   endtask

   // Dispenser and ejector: random ack latency, occasional stray acks when idle.
   initial begin
      bus.disp_ack = 1'b0;
      bus.coin_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.disp_ack = bus.disp_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         bus.coin_ack = bus.coin_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      end
   end

   initial begin : monitor
      bit   pd;
      bit   pc;
      int   cur;
      exp_t e;
      bit   ok;
      pd  = 1'b0;
      pc  = 1'b0;
      cur = -1;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            pd = bus.disp_req;
            pc = bus.coin_req;
         end else begin
            if (bus.disp_req && !pd) begin
               take(EvDisp, "disp_req_event", e, ok);
               if (ok) begin
                  check("disp_credit", int'(bus.credit), e.val);
                  check("disp_product", int'(bus.product), e.prod);
               end
            end
            if (bus.coin_req) begin
               if (!pc) begin
                  take(EvCoin, "coin_req_event", e, ok);
                  cur = ok ? e.val : -1;
                  if (ok) check("coin_type", int'(bus.coin_type), cur);
               end else if (cur >= 0) begin
                  check("coin_type_stable", int'(bus.coin_type), cur);
               end
            end
            if (bus.delivered) begin
               take(EvDeliv, "delivered_event", e, ok);
               if (ok) check("deliv_credit", int'(bus.credit), 0);
            end
            if (bus.bad_coin) take(EvBad, "bad_coin_event", e, ok);
            pd = bus.disp_req;
            pc = bus.coin_req;
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0] bad_codes [4];
      logic [2:0] good_codes [3];
      int         n;
      int         cancel_after;
      int         w;
      bad_codes  = '{3'b011, 3'b101, 3'b110, 3'b111};
      good_codes = '{3'b001, 3'b010, 3'b100};
      total = 0;
      bad   = 0;
      reset        = 1'b1;
      bus.BTN1     = 1'b0;
      bus.BTN2     = 1'b0;
      bus.BTN3     = 1'b0;
      bus.cancel   = 1'b0;
      bus.Money_in = 3'b000;
      repeat (2) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Exact payment, no change.
      plan = '{3'b010};
      run_txn(3'b001, -1);
      // 5zl for tea: change 2 then 1.
      plan = '{3'b100};
      run_txn(3'b001, -1);
      // BTN1 wins over BTN3; vends at 2.
      plan = '{3'b001, 3'b001, 3'b001, 3'b001};
      run_txn(3'b101, -1);
      // Cancel refunds the 2zl, nothing delivered.
      plan = '{3'b010};
      run_txn(3'b100, 1);

      // Held coin counts once; reserved code only pulses bad_coin.
      start_txn(3'b100);
      coin_step(3'b010, 20);
      check("held_credit", int'(bus.credit), 2);
      coin_step(3'b011, 1);
      check("bad_code_credit", int'(bus.credit), 2);
      do_cancel();
      finish_txn();

      // Reset while paying change.
      start_txn(3'b010);
      coin_step(3'b100, 1);
      w = 0;
      while (!bus.coin_req && w < 100) begin
         tick();
         w++;
      end
      check("change_coin_req_seen", int'(bus.coin_req), 1);
      reset = 1'b1;
      tick();
      check_all_zero("mid_reset");
      reset = 1'b0;
      expq.delete();
      repeat (3) tick();
      check("post_reset_busy", int'(bus.busy), 0);

      for (int t = 0; t < 24; t++) begin
         n = int'($urandom_range(1, 4));
         plan.delete();
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 4) == 0) plan.push_back(bad_codes[$urandom_range(0, 3)]);
            else                           plan.push_back(good_codes[$urandom_range(0, 2)]);
         end
         cancel_after = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         run_txn(3'($urandom_range(1, 7)), cancel_after);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
